// File: rtl/mod13_display_driver_pkg.sv
// Shared constants for the mod-13 display driver slice.
//   MOD13_MAX          highest legal counter value (12)
//   SEG_BLANK/SEG_DASH active-high patterns for an unlit digit and a lone "g"
//   SEG_TABLE          active-high {a,b,c,d,e,f,g} patterns for digits 0..9
//   DIG_ONES/DIG_TENS  digit-select encoding (also the an[] bit index)
package mod13_display_driver_pkg;

    localparam logic [3:0] MOD13_MAX = 4'd12;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h01;

    localparam logic [6:0] SEG_TABLE [0:9] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
        7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B
    };

    localparam logic DIG_ONES = 1'b0;
    localparam logic DIG_TENS = 1'b1;

    // Digit lookup; anything outside 0..9 renders blank rather than garbage.
    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        if (d <= 4'd9) begin
            return SEG_TABLE[d];
        end
        return SEG_BLANK;
    endfunction

endpackage

// File: rtl/mod13_display_driver_if.sv
// Signal bundle between the mod-13 counter side and the display driver.
//   count      counter value, nominal 0..12 (sampled every clock)
//   freeze     1 = keep the currently displayed value
//   seg        segments {a,b,c,d,e,f,g}, seg[6]=a
//   an         one-hot digit enables, an[0]=ones, an[1]=tens
//   wrap_pulse one-cycle pulse after the raw count stepped 12 -> 0
//   invalid    1 while the displayed value is 13..15
// There is no valid/ready handshake: count and freeze are level inputs
// sampled on every rising clock edge, and all outputs are registered levels
// (wrap_pulse is a single-cycle level).
interface mod13_display_driver_if;
    logic [3:0] count;
    logic       freeze;
    logic [6:0] seg;
    logic [1:0] an;
    logic       wrap_pulse;
    logic       invalid;

    // Counter / environment side.
    modport master (
        output count,
        output freeze,
        input  seg,
        input  an,
        input  wrap_pulse,
        input  invalid
    );

    // Display driver side.
    modport slave (
        input  count,
        input  freeze,
        output seg,
        output an,
        output wrap_pulse,
        output invalid
    );
endinterface

// File: rtl/mod13_display_driver_seg7_decoder.sv
// Combinational 7-segment decoder.
//   digit_i  4-bit digit value (0..9)
//   blank_i  1 = digit unlit
//   dash_i   1 = show a dash (g only); wins over blank_i
//   seg_o    active-high pattern {a,b,c,d,e,f,g}
module mod13_display_driver_seg7_decoder
    import mod13_display_driver_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    input  logic       dash_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = digit_to_seg(digit_i);
        if (dash_i) begin
            seg_o = SEG_DASH;
        end else if (blank_i) begin
            seg_o = SEG_BLANK;
        end
    end

endmodule

// File: rtl/mod13_display_driver.sv
// Mod-13 counter display driver: splits the counter value into two decimal
// digits, time-multiplexes them onto a 2-digit 7-segment display, flags the
// 12 -> 0 wrap and flags illegal codes 13..15.
//   clock  system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    slave side of mod13_display_driver_if (count/freeze in,
//          seg/an/wrap_pulse/invalid out)
// Parameters: REFRESH_DIV cycles per digit (>=2); SEG_ACTIVE_LOW output polarity.
module mod13_display_driver
    import mod13_display_driver_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset,
    mod13_display_driver_if.slave       bus
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_RESET = SEG_ACTIVE_LOW ? ~SEG_TABLE[0] : SEG_TABLE[0];
    localparam logic [1:0] AN_RESET  = SEG_ACTIVE_LOW ? 2'b10 : 2'b01;

    logic [3:0]    disp_q,  disp_d;
    logic [3:0]    prev_q;
    logic [CW-1:0] refresh_q, refresh_d;
    logic          sel_q,   sel_d;
    logic [6:0]    seg_q,   seg_d;
    logic [1:0]    an_q,    an_d;
    logic          wrap_q,  wrap_d;
    logic          inv_q,   inv_d;

    logic [3:0]    digit;
    logic          blank;
    logic          dash;
    logic [6:0]    pattern;

    // Next-state for the display, refresh and wrap logic.
    always_comb begin
        disp_d    = bus.freeze ? disp_q : bus.count;
        wrap_d    = (prev_q == MOD13_MAX) && (bus.count == 4'd0);
        refresh_d = refresh_q + CW'(1);
        sel_d     = sel_q;
        if (refresh_q == REFRESH_LAST) begin
            refresh_d = '0;
            sel_d     = ~sel_q;
        end
    end

    // Digit split of the current display value for the currently selected digit.
    always_comb begin
        dash  = (disp_q > MOD13_MAX);
        digit = (disp_q >= 4'd10) ? (disp_q - 4'd10) : disp_q;
        blank = 1'b0;
        if (sel_q == DIG_TENS) begin
            digit = 4'd1;
            blank = (disp_q < 4'd10);
        end
    end

    mod13_display_driver_seg7_decoder u_seg7_decoder (
        .digit_i (digit),
        .blank_i (blank),
        .dash_i  (dash),
        .seg_o   (pattern)
    );

    // seg and an are registered from the same sel_q, so a digit switch and
    // the pattern for the new digit always land on the same edge.
    always_comb begin
        seg_d = SEG_ACTIVE_LOW ? ~pattern : pattern;
        an_d  = (sel_q == DIG_TENS) ? 2'b10 : 2'b01;
        if (SEG_ACTIVE_LOW) begin
            an_d = ~an_d;
        end
        inv_d = dash;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            disp_q    <= 4'd0;
            prev_q    <= 4'd0;
            refresh_q <= '0;
            sel_q     <= DIG_ONES;
            seg_q     <= SEG_RESET;
            an_q      <= AN_RESET;
            wrap_q    <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            disp_q    <= disp_d;
            prev_q    <= bus.count;
            refresh_q <= refresh_d;
            sel_q     <= sel_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            wrap_q    <= wrap_d;
            inv_q     <= inv_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.wrap_pulse = wrap_q;
    assign bus.invalid    = inv_q;

endmodule

// File: tb/tb_mod13_display_driver.sv
module tb_mod13_display_driver;

    localparam int DIV = 4;

    logic clock;
    logic reset;

    mod13_display_driver_if bus ();

    mod13_display_driver #(
        .REFRESH_DIV    (DIV),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    int n_wrap = 0;

    // exp_q[k]: value the display should hold after edge k (index 0 = reset).
    logic [3:0] exp_q[$];
    // cnt_hist[k]: raw count presented at edge k (index 0 = reset value of prev).
    logic [3:0] cnt_hist[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Reference: decimal rendering of a value on one digit, active-low.
    function automatic logic [6:0] ref_seg(input int v, input bit tens);
        logic [6:0] codes [0:9];
        logic [6:0] hi;
        codes = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
        if (v >= 13)      hi = 7'h01;
        else if (tens)    hi = (v >= 10) ? codes[v / 10] : 7'h00;
        else              hi = codes[v % 10];
        return ~hi;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        cnt_hist.delete();
        exp_q.push_back(4'd0);
        cnt_hist.push_back(4'd0);
    endtask

    // Drive one cycle of stimulus, then check every output against the model.
    task automatic step(input logic [3:0] c, input logic f);
        int  k;
        bit  tens_phase;
        int  shown;
        bit  exp_wrap;
        bus.count  = c;
        bus.freeze = f;
        @(posedge clock);
        #1;
        cnt_hist.push_back(c);
        k = cnt_hist.size() - 1;
        exp_q.push_back(f ? exp_q[k-1] : c);
        // Outputs after edge k reflect the display value and digit phase before it.
        shown      = int'(exp_q[k-1]);
        tens_phase = (((k - 1) / DIV) % 2) == 1;
        exp_wrap   = (cnt_hist[k-1] == 4'd12) && (c == 4'd0);
        if (exp_wrap) n_wrap++;
        check("seg",     {25'd0, bus.seg}, {25'd0, ref_seg(shown, tens_phase)});
        check("an",      {30'd0, bus.an}, tens_phase ? 32'd1 : 32'd2);
        check("wrap",    {31'd0, bus.wrap_pulse}, {31'd0, exp_wrap});
        check("invalid", {31'd0, bus.invalid}, {31'd0, (shown >= 13)});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"},  {25'd0, bus.seg}, 32'h01);
        check({tag, "_an"},   {30'd0, bus.an}, 32'd2);
        check({tag, "_wrap"}, {31'd0, bus.wrap_pulse}, 32'd0);
        check({tag, "_inv"},  {31'd0, bus.invalid}, 32'd0);
    endtask

    int wraps_seen;

    initial begin
        reset      = 1'b0;
        bus.count  = 4'd0;
        bus.freeze = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("rst");
        reset = 1'b1;

        // Steady value, full ones + tens refresh periods.
        repeat (2 * DIV + 2) step(4'd7, 1'b0);
        repeat (2 * DIV + 2) step(4'd11, 1'b0);
        repeat (2 * DIV + 2) step(4'd12, 1'b0);

        // 11,12,0 wrap, then 5 -> 0 (no pulse).
        n_wrap = 0;
        step(4'd11, 1'b0);
        step(4'd12, 1'b0);
        step(4'd0, 1'b0);
        step(4'd0, 1'b0);
        step(4'd5, 1'b0);
        step(4'd0, 1'b0);
        step(4'd0, 1'b0);
        check("wrap_count_a", n_wrap, 1);

        // Freeze at 9 across a wrap.
        step(4'd9, 1'b0);
        step(4'd9, 1'b0);
        n_wrap = 0;
        wraps_seen = 0;
        foreach (cnt_hist[i]) begin end
        step(4'd10, 1'b1); wraps_seen += int'(bus.wrap_pulse);
        step(4'd11, 1'b1); wraps_seen += int'(bus.wrap_pulse);
        step(4'd12, 1'b1); wraps_seen += int'(bus.wrap_pulse);
        step(4'd0,  1'b1); wraps_seen += int'(bus.wrap_pulse);
        repeat (2 * DIV) begin
            step(4'd0, 1'b1);
            wraps_seen += int'(bus.wrap_pulse);
        end
        check("frozen_wraps", wraps_seen, 1);
        check("frozen_model_wraps", n_wrap, 1);

        // Illegal code.
        repeat (2 * DIV + 2) step(4'd14, 1'b0);

        // Asynchronous reset in the middle of a refresh period.
        step(4'd14, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();

        // Randomized traffic, biased toward the 12/0 boundary.
        for (int i = 0; i < 300; i++) begin
            logic [3:0] c;
            logic       f;
            if ($urandom_range(0, 9) < 3)
                c = ($urandom_range(0, 1) == 1) ? 4'd12 : 4'd0;
            else
                c = 4'($urandom_range(0, 15));
            f = ($urandom_range(0, 4) == 0);
            step(c, f);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
